// File: rtl/id_queue_stage.sv
// id_queue_stage: buffered decode stage. A DEPTH-entry instruction queue sits between
// fetch and decode. The queue head is decoded (controller, regfile, immediate extend)
// into a registered ID/EX output with valid/ready handshakes. It provides backpressure,
// flush, a load-use interlock and regfile write-through.
// Optional feature macro: ID_QUEUE_BYPASS_EN. When it is defined, an entry that arrives
// at an empty queue is decoded directly and can issue at its own handshake edge.
module id_queue_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [XLEN-1:0]              in_pcplus4,
  input  logic                         flush,
  input  logic                         RegWriteW,
  input  logic [4:0]                   RdW,
  input  logic [XLEN-1:0]              ResultW,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_pcplus4,
  output logic [XLEN-1:0]              out_rd1,
  output logic [XLEN-1:0]              out_rd2,
  output logic [XLEN-1:0]              out_imm,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [4:0]                   out_rd,
  output logic [2:0]                   out_funct3,
  output logic [1:0]                   out_ResultSrc,
  output logic [3:0]                   out_ALUControl,
  output logic                         out_RegWrite,
  output logic                         out_MemWrite,
  output logic                         out_Jump,
  output logic                         out_Branch,
  output logic                         out_ALUSrc,
  output logic                         out_SrcAsrc,
  output logic                         out_jumpReg,
  output logic                         out_is_word_op,
  output logic [4:0]                   Rs1D,
  output logic [4:0]                   Rs2D,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc, pcplus4, rd1, rd2, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic [1:0]      result_src;
    logic [3:0]      alu_control;
    logic            reg_write, mem_write, jump, branch;
    logic            alu_src, srca_src, jump_reg, is_word_op;
  } idex_t;

  // Queue storage (data only, no reset) and control state
  logic [31:0]     q_instr  [DEPTH];
  logic [XLEN-1:0] q_pc     [DEPTH];
  logic [XLEN-1:0] q_pcplus4[DEPTH];
  logic [XLEN-1:0] rf_q     [32];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q;
  idex_t           idex_q, dec;

  logic            bypass, have_entry, load_ok, hazard, issue, push, pop;
  logic [31:0]     d_instr;
  logic [XLEN-1:0] d_pc, d_pcplus4, rd1, rd2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [4:0]      d_rs1, d_rs2;

  // Select the entry presented to decode: queue head, or the incoming word when bypassing
  always_comb begin
    bypass = 1'b0;
`ifdef ID_QUEUE_BYPASS_EN
    bypass = (count_q == '0) && in_valid && load_ok && !flush;
`endif
    if (bypass) begin
      d_instr   = in_instr;
      d_pc      = in_pc;
      d_pcplus4 = in_pcplus4;
    end else begin
      d_instr   = q_instr[rd_ptr_q];
      d_pc      = q_pc[rd_ptr_q];
      d_pcplus4 = q_pcplus4[rd_ptr_q];
    end
  end

  assign d_rs1      = d_instr[19:15];
  assign d_rs2      = d_instr[24:20];
  assign have_entry = bypass || (count_q != '0);
  assign load_ok    = !out_valid_q || out_ready;
  // A load in ID/EX whose destination feeds the candidate must stall one cycle
  assign hazard     = out_valid_q && (idex_q.result_src == 2'b01) && (idex_q.rd != 5'd0) &&
                      ((idex_q.rd == d_rs1) || (idex_q.rd == d_rs2));
  assign issue      = have_entry && load_ok && !hazard && !flush;
  assign in_ready   = (count_q != CW'(DEPTH)) && !flush;
  // A bypassed entry that issues never touches the queue
  assign push       = in_valid && in_ready && !(bypass && issue);
  assign pop        = issue && !bypass;
  assign count_d    = count_q + CW'(push) - CW'(pop);

  // Regfile read with same-cycle write-through; x0 is hard zero
  assign rd1 = (d_rs1 == 5'd0) ? '0 : (RegWriteW && (RdW == d_rs1)) ? ResultW : rf_q[d_rs1];
  assign rd2 = (d_rs2 == 5'd0) ? '0 : (RegWriteW && (RdW == d_rs2)) ? ResultW : rf_q[d_rs2];

  // Immediate extend for each instruction format
  assign imm_i = {{(XLEN-12){d_instr[31]}}, d_instr[31:20]};
  assign imm_s = {{(XLEN-12){d_instr[31]}}, d_instr[31:25], d_instr[11:7]};
  assign imm_b = {{(XLEN-13){d_instr[31]}}, d_instr[31], d_instr[7], d_instr[30:25],
                  d_instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){d_instr[31]}}, d_instr[31], d_instr[19:12], d_instr[20],
                  d_instr[30:21], 1'b0};
  assign imm_u = XLEN'($signed({d_instr[31:12], 12'b0}));

  // Controller: decode the selected entry into the ID/EX payload
  always_comb begin
    dec         = '0;
    dec.pc      = d_pc;
    dec.pcplus4 = d_pcplus4;
    dec.rd1     = rd1;
    dec.rd2     = rd2;
    dec.rs1     = d_rs1;
    dec.rs2     = d_rs2;
    dec.rd      = d_instr[11:7];
    dec.funct3  = d_instr[14:12];
    case (d_instr[6:0])
      7'b0110011, 7'b0111011: begin  // R-type, word variant when bit 3 set
        dec.reg_write   = 1'b1;
        dec.alu_control = {d_instr[30], d_instr[14:12]};
        dec.is_word_op  = d_instr[3];
      end
      7'b0010011, 7'b0011011: begin  // I-type ALU; bit 30 only selects SRAI
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.imm         = imm_i;
        dec.alu_control = {(d_instr[14:12] == 3'b101) && d_instr[30], d_instr[14:12]};
        dec.is_word_op  = d_instr[3];
      end
      7'b0000011: begin  // load
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
        dec.imm        = imm_i;
      end
      7'b0100011: begin  // store
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_s;
      end
      7'b1100011: begin  // branch compares by subtraction
        dec.branch      = 1'b1;
        dec.alu_control = 4'b1000;
        dec.imm         = imm_b;
      end
      7'b1101111: begin  // jal
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.imm        = imm_j;
      end
      7'b1100111: begin  // jalr
        dec.jump       = 1'b1;
        dec.jump_reg   = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b10;
        dec.imm        = imm_i;
      end
      7'b0110111: begin  // lui writes the immediate directly
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b11;
        dec.imm        = imm_u;
      end
      7'b0010111: begin  // auipc adds the immediate to the PC
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.srca_src  = 1'b1;
        dec.imm       = imm_u;
      end
      default: ;
    endcase
  end

  // Queue data write; storage needs no reset because occupancy guards every read
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr_q]   <= in_instr;
      q_pc[wr_ptr_q]      <= in_pc;
      q_pcplus4[wr_ptr_q] <= in_pcplus4;
    end
  end

  // Regfile write port; x0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (RegWriteW && (RdW != 5'd0)) begin
      rf_q[RdW] <= ResultW;
    end
  end

  // Pointers, occupancy and the ID/EX register (issue, bubble, hold, flush)
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      idex_q      <= '0;
    end else begin
      if (flush) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        count_q <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (issue) begin
        idex_q      <= dec;
        out_valid_q <= 1'b1;
      end else if (load_ok || flush) begin
        out_valid_q      <= 1'b0;
        idex_q.reg_write <= 1'b0;
        idex_q.mem_write <= 1'b0;
        idex_q.jump      <= 1'b0;
        idex_q.branch    <= 1'b0;
        idex_q.jump_reg  <= 1'b0;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = idex_q.pc;
  assign out_pcplus4    = idex_q.pcplus4;
  assign out_rd1        = idex_q.rd1;
  assign out_rd2        = idex_q.rd2;
  assign out_imm        = idex_q.imm;
  assign out_rs1        = idex_q.rs1;
  assign out_rs2        = idex_q.rs2;
  assign out_rd         = idex_q.rd;
  assign out_funct3     = idex_q.funct3;
  assign out_ResultSrc  = idex_q.result_src;
  assign out_ALUControl = idex_q.alu_control;
  assign out_RegWrite   = idex_q.reg_write;
  assign out_MemWrite   = idex_q.mem_write;
  assign out_Jump       = idex_q.jump;
  assign out_Branch     = idex_q.branch;
  assign out_ALUSrc     = idex_q.alu_src;
  assign out_SrcAsrc    = idex_q.srca_src;
  assign out_jumpReg    = idex_q.jump_reg;
  assign out_is_word_op = idex_q.is_word_op;
  assign Rs1D           = have_entry ? d_rs1 : 5'd0;
  assign Rs2D           = have_entry ? d_rs2 : 5'd0;
  assign occupancy      = count_q;

endmodule

// File: tb/tb_id_queue_stage.sv
// tb_id_queue_stage: directed stimulus for id_queue_stage.
// A queue-level reference model is compared against the DUT on every falling edge.
// Literal expectations are taken from the documented scenarios.
module tb_id_queue_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, RegWriteW, out_ready;
  logic [31:0] in_instr, in_pc, in_pcplus4, ResultW;
  logic [4:0]  RdW;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_pcplus4, out_rd1, out_rd2, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd, Rs1D, Rs2D;
  logic [2:0]  out_funct3;
  logic [1:0]  out_ResultSrc;
  logic [3:0]  out_ALUControl;
  logic        out_RegWrite, out_MemWrite, out_Jump, out_Branch;
  logic        out_ALUSrc, out_SrcAsrc, out_jumpReg, out_is_word_op;
  logic [2:0]  occupancy;

  id_queue_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_pcplus4(in_pcplus4), .flush(flush),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_rd1(out_rd1), .out_rd2(out_rd2),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_ResultSrc(out_ResultSrc), .out_ALUControl(out_ALUControl),
    .out_RegWrite(out_RegWrite), .out_MemWrite(out_MemWrite), .out_Jump(out_Jump),
    .out_Branch(out_Branch), .out_ALUSrc(out_ALUSrc), .out_SrcAsrc(out_SrcAsrc),
    .out_jumpReg(out_jumpReg), .out_is_word_op(out_is_word_op),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, pcp4;
  } ent_t;

  typedef struct {
    logic [31:0] pc, pcp4, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [1:0]  rsrc;
    logic [3:0]  aluc;
    logic        regw, memw, jump, branch, alusrc, srca, jreg, word;
  } idex_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 0;
  bit          rec_en = 0;
  ent_t        mq[$];
  bit          mv;
  idex_t       mo;
  logic [31:0] mrf[32];
  logic [31:0] got_pc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference register read: x0 is zero, a same-cycle writeback wins over the stored value
  function automatic logic [31:0] rdval(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWriteW && RdW == a) return ResultW;
    return mrf[a];
  endfunction

  // Reference decode for the instruction kinds this bench issues
  function automatic idex_t mdec(input ent_t e);
    idex_t r;
    logic [6:0] opc;
    r = '{default: '0};
    opc = e.instr[6:0];
    r.pc = e.pc;
    r.pcp4 = e.pcp4;
    r.rs1 = e.instr[19:15];
    r.rs2 = e.instr[24:20];
    r.rd = e.instr[11:7];
    r.f3 = e.instr[14:12];
    r.rd1 = rdval(r.rs1);
    r.rd2 = rdval(r.rs2);
    if (opc == 7'h33) begin
      r.regw = 1;
      r.aluc = {e.instr[30], e.instr[14:12]};
    end else if (opc == 7'h13) begin
      r.regw = 1;
      r.alusrc = 1;
      r.imm = $signed(e.instr) >>> 20;
      r.aluc = {(e.instr[14:12] == 3'd5) && e.instr[30], e.instr[14:12]};
    end else if (opc == 7'h03) begin
      r.regw = 1;
      r.alusrc = 1;
      r.rsrc = 2'b01;
      r.imm = $signed(e.instr) >>> 20;
    end
    return r;
  endfunction

  function automatic void kill_ctrl();
    mv = 0;
    mo.regw = 0;
    mo.memw = 0;
    mo.jump = 0;
    mo.branch = 0;
    mo.jreg = 0;
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, rd, 7'h13};
  endfunction

  // Candidate entry for decode in the current cycle, if any
  function automatic bit cand(output ent_t e);
    e = '{default: '0};
    if (mq.size() > 0) begin
      e = mq[0];
      return 1;
    end
`ifdef ID_QUEUE_BYPASS_EN
    if (in_valid && (!mv || out_ready) && !flush) begin
      e = '{in_instr, in_pc, in_pcplus4};
      return 1;
    end
`endif
    return 0;
  endfunction

  // Reference model: advances one cycle on every rising edge
  always @(posedge clk) begin
    ent_t c, inc;
    bit has, rdy, lok, hz, iss, byp;
    if (reset) begin
      mq.delete();
      mv = 0;
      mo = '{default: '0};
      for (int i = 0; i < 32; i++) mrf[i] = '0;
    end else begin
      rdy = (mq.size() != DEPTH) && !flush;
      lok = !mv || out_ready;
      inc = '{in_instr, in_pc, in_pcplus4};
      if (flush) begin
        mq.delete();
        kill_ctrl();
      end else begin
        byp = (mq.size() == 0);
        has = cand(c);
        hz = mv && mo.rsrc == 2'b01 && mo.rd != 0 && (mo.rd == c.instr[19:15] || mo.rd == c.instr[24:20]);
        iss = has && lok && !hz;
        if (iss) begin
          mo = mdec(c);
          mv = 1;
          if (!byp) void'(mq.pop_front());
        end else if (lok) begin
          kill_ctrl();
        end
        if (in_valid && rdy && !(byp && iss && has)) mq.push_back(inc);
      end
      if (RegWriteW && RdW != 0) mrf[RdW] = ResultW;
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    ent_t c;
    bit has;
    if (chk_en) begin
      has = cand(c);
      chk("out_valid", out_valid, mv);
      chk("out_pc", out_pc, mo.pc);
      chk("out_pcplus4", out_pcplus4, mo.pcp4);
      chk("out_rd1", out_rd1, mo.rd1);
      chk("out_rd2", out_rd2, mo.rd2);
      chk("out_imm", out_imm, mo.imm);
      chk("out_rs1", out_rs1, mo.rs1);
      chk("out_rs2", out_rs2, mo.rs2);
      chk("out_rd", out_rd, mo.rd);
      chk("out_funct3", out_funct3, mo.f3);
      chk("out_ResultSrc", out_ResultSrc, mo.rsrc);
      chk("out_ALUControl", out_ALUControl, mo.aluc);
      chk("out_RegWrite", out_RegWrite, mo.regw);
      chk("out_MemWrite", out_MemWrite, mo.memw);
      chk("out_Jump", out_Jump, mo.jump);
      chk("out_Branch", out_Branch, mo.branch);
      chk("out_ALUSrc", out_ALUSrc, mo.alusrc);
      chk("out_SrcAsrc", out_SrcAsrc, mo.srca);
      chk("out_jumpReg", out_jumpReg, mo.jreg);
      chk("out_is_word_op", out_is_word_op, mo.word);
      chk("in_ready", in_ready, (mq.size() != DEPTH) && !flush);
      chk("occupancy", occupancy, mq.size());
      chk("Rs1D", Rs1D, has ? c.instr[19:15] : 5'd0);
      chk("Rs2D", Rs2D, has ? c.instr[24:20] : 5'd0);
      if (rec_en && out_valid && out_ready) got_pc.push_back(out_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1;
    in_instr = ins;
    in_pc = pc;
    in_pcplus4 = pc + 4;
  endtask

  initial begin
    int i, cyc;
    bit acc;
    reset = 1; in_valid = 0; flush = 0; RegWriteW = 0; out_ready = 0;
    in_instr = 0; in_pc = 0; in_pcplus4 = 0; ResultW = 0; RdW = 0;
    tick();
    chk_en = 1;
    tick();
    tick();
    chk("reset out_valid", out_valid, 0);
    chk("reset occupancy", occupancy, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_pc", out_pc, 0);
    reset = 0;

    // addi x1,x0,5 at 0x100: valid two edges after the handshake
    out_ready = 1;
    offer(32'h00500093, 32'h100);
    tick();
    in_valid = 0;
    chk("lat1 out_valid", out_valid, 0);
    tick();
    chk("lat2 out_valid", out_valid, 1);
    chk("lat2 out_pc", out_pc, 32'h100);
    chk("lat2 out_imm", out_imm, 5);
    chk("lat2 out_rd", out_rd, 1);
    chk("lat2 out_RegWrite", out_RegWrite, 1);
    tick();

    // Backpressure: five offers with out_ready low
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      offer(addi(5'(10 + k), 12'(k)), 32'h200 + 4 * k);
      tick();
    end
    chk("full occupancy", occupancy, 4);
    chk("full in_ready", in_ready, 0);
    chk("full out_pc", out_pc, 32'h200);
    offer(addi(5'd20, 12'd9), 32'h2F0);
    tick();
    tick();
    chk("hold occupancy", occupancy, 4);
    chk("hold out_pc", out_pc, 32'h200);
    chk("hold out_rd", out_rd, 10);
    in_valid = 0;
    out_ready = 1;
    repeat (6) tick();

    // Load-use: lw x5,0(x2) then add x6,x5,x1 -> one bubble
    offer(32'h00012283, 32'h300);
    tick();
    offer(32'h00128333, 32'h304);
    tick();
    in_valid = 0;
    chk("lw out_rd", out_rd, 5);
    chk("lw out_ResultSrc", out_ResultSrc, 1);
    tick();
    chk("bubble out_valid", out_valid, 0);
    chk("bubble out_RegWrite", out_RegWrite, 0);
    tick();
    chk("add out_valid", out_valid, 1);
    chk("add out_pc", out_pc, 32'h304);
    chk("add out_rd", out_rd, 6);

    // Write-through: add x7,x3,x0 issues while x3 is being written
    offer(32'h000183B3, 32'h320);
    tick();
    in_valid = 0;
    RegWriteW = 1; RdW = 3; ResultW = 32'hDEAD;
    tick();
    RegWriteW = 0;
    chk("wt out_rd1", out_rd1, 32'hDEAD);
    offer(32'h00018433, 32'h324);
    tick();
    in_valid = 0;
    RegWriteW = 1; RdW = 0; ResultW = 32'hBEEF;
    tick();
    RegWriteW = 0;
    chk("rd0 out_rd1", out_rd1, 32'hDEAD);
    chk("rd0 out_rd2", out_rd2, 0);

    // Flush with three entries queued; the offer during flush is dropped
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      offer(addi(5'(21 + k), 12'(k)), 32'h500 + 4 * k);
      tick();
    end
    chk("preflush occupancy", occupancy, 3);
    flush = 1;
    offer(addi(5'd25, 12'd1), 32'h50C);
    #1;
    chk("flush in_ready", in_ready, 0);
    tick();
    flush = 0;
    in_valid = 0;
    chk("flush occupancy", occupancy, 0);
    chk("flush out_valid", out_valid, 0);
    tick();
    chk("postflush occupancy", occupancy, 0);

    // Wrap: ten entries streamed with out_ready toggling
    rec_en = 1;
    i = 0;
    cyc = 0;
    while (i < 10 && cyc < 200) begin
      offer(addi(5'(i + 1), 12'(i)), 32'h400 + 4 * i);
      out_ready = cyc[0];
      #1;
      acc = in_ready;
      tick();
      if (acc) i++;
      cyc++;
    end
    chk("stream finished in budget", i, 10);
    in_valid = 0;
    out_ready = 1;
    repeat (8) tick();
    rec_en = 0;
    chk("stream count", got_pc.size(), 10);
    for (int k = 0; k < 10 && k < got_pc.size(); k++)
      chk("stream order", got_pc[k], 32'h400 + 4 * k);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
